// File: rtl/mp3_frame_sync.sv
// mp3_frame_sync: MPEG-1 Layer III byte-stream frame synchroniser.
// Hunts for a header, confirms it at frame boundaries, forwards payload.
module mp3_frame_sync #(
    parameter int LOCK_COUNT = 2,
    parameter bit PASS_CRC   = 1'b0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  axiid,
    input  logic        axiiv,
    output logic [7:0]  axiod,
    output logic        axiov,
    output logic        frame_start,
    output logic        locked,
    output logic        sync_lost,
    output logic        prot,
    output logic        padding,
    output logic [1:0]  samp_rate,
    output logic [1:0]  mode,
    output logic [1:0]  mode_ext,
    output logic [1:0]  emphasis,
    output logic [3:0]  bitrate_idx,
    output logic [10:0] frame_size
);

    typedef enum logic [1:0] {HUNT, CONFIRM, LOCKED} state_t;

    localparam logic [2:0] LC = 3'(LOCK_COUNT);

    state_t      state;
    // Only the low three bytes of history ever reach a candidate word.
    logic [23:0] sr;
    logic [10:0] idx;
    logic [10:0] fsz;
    logic [2:0]  match;
    logic [2:0]  ref_id;
    logic [1:0]  ref_sf;
    logic [13:0] hdr_q;

    logic [31:0] cand;
    logic        hdr_ok;
    logic        bnd_ok;
    logic        at_hdr;
    logic        fwd;
    logic [10:0] cand_fs;
    logic [10:0] idx_nxt;

    function automatic logic [10:0] frame_bytes(
        input logic [3:0] br,
        input logic [1:0] sf,
        input logic       pad
    );
        logic [8:0]  kbps;
        logic [10:0] tab;
        logic [11:0] x9;
        logic [10:0] base;
        case (br)
            4'd1:    begin kbps = 9'd32;  tab = 11'd104;  end
            4'd2:    begin kbps = 9'd40;  tab = 11'd130;  end
            4'd3:    begin kbps = 9'd48;  tab = 11'd156;  end
            4'd4:    begin kbps = 9'd56;  tab = 11'd182;  end
            4'd5:    begin kbps = 9'd64;  tab = 11'd208;  end
            4'd6:    begin kbps = 9'd80;  tab = 11'd261;  end
            4'd7:    begin kbps = 9'd96;  tab = 11'd313;  end
            4'd8:    begin kbps = 9'd112; tab = 11'd365;  end
            4'd9:    begin kbps = 9'd128; tab = 11'd417;  end
            4'd10:   begin kbps = 9'd160; tab = 11'd522;  end
            4'd11:   begin kbps = 9'd192; tab = 11'd626;  end
            4'd12:   begin kbps = 9'd224; tab = 11'd731;  end
            4'd13:   begin kbps = 9'd256; tab = 11'd835;  end
            4'd14:   begin kbps = 9'd320; tab = 11'd1044; end
            default: begin kbps = 9'd0;   tab = 11'd0;    end
        endcase
        x9 = {kbps, 3'b000} + {3'b000, kbps};
        case (sf)
            2'b00:   base = tab;
            2'b01:   base = {2'b00, kbps} + {1'b0, kbps, 1'b0};
            default: base = x9[11:1];
        endcase
        return base + {10'd0, pad};
    endfunction

    // Candidate header decode and frame position bookkeeping.
    always_comb begin
        cand    = {sr, axiid};
        hdr_ok  = (cand[31:20] == 12'hFFF) && cand[19] &&
                  (cand[18:17] == 2'b01) &&
                  (cand[15:12] != 4'h0) && (cand[15:12] != 4'hF) &&
                  (cand[11:10] != 2'b11) && (cand[1:0] != 2'b10);
        bnd_ok  = hdr_ok && (cand[19:17] == ref_id) &&
                  (cand[11:10] == ref_sf);
        cand_fs = frame_bytes(cand[15:12], cand[11:10], cand[9]);
        at_hdr  = (idx == 11'd3);
        idx_nxt = (idx == fsz - 11'd1) ? 11'd0 : idx + 11'd1;
        fwd     = (idx >= 11'd4) && (PASS_CRC || prot || idx > 11'd5);
    end

    // Hunt/confirm/locked state machine with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= HUNT;
            sr          <= '0;
            idx         <= '0;
            fsz         <= '0;
            match       <= '0;
            ref_id      <= '0;
            ref_sf      <= '0;
            hdr_q       <= '0;
            frame_size  <= '0;
            axiod       <= '0;
            axiov       <= 1'b0;
            frame_start <= 1'b0;
            locked      <= 1'b0;
            sync_lost   <= 1'b0;
        end else begin
            axiov       <= 1'b0;
            frame_start <= 1'b0;
            sync_lost   <= 1'b0;
            if (axiiv) begin
                sr <= cand[23:0];
                unique case (state)
                    HUNT: begin
                        if (hdr_ok) begin
                            ref_id <= cand[19:17];
                            ref_sf <= cand[11:10];
                            fsz    <= cand_fs;
                            idx    <= 11'd4;
                            match  <= 3'd1;
                            if (LC == 3'd1) begin
                                state       <= LOCKED;
                                locked      <= 1'b1;
                                frame_start <= 1'b1;
                                frame_size  <= cand_fs;
                                hdr_q <= {cand[16:9], cand[7:4], cand[1:0]};
                            end else begin
                                state <= CONFIRM;
                            end
                        end
                    end
                    CONFIRM: begin
                        idx <= idx_nxt;
                        if (at_hdr) begin
                            if (bnd_ok) begin
                                fsz   <= cand_fs;
                                match <= match + 3'd1;
                                if (match + 3'd1 == LC) begin
                                    state       <= LOCKED;
                                    locked      <= 1'b1;
                                    frame_start <= 1'b1;
                                    frame_size  <= cand_fs;
                                    hdr_q <= {cand[16:9], cand[7:4], cand[1:0]};
                                end
                            end else begin
                                state <= HUNT;
                            end
                        end
                    end
                    LOCKED: begin
                        idx <= idx_nxt;
                        if (at_hdr) begin
                            if (bnd_ok) begin
                                fsz         <= cand_fs;
                                frame_start <= 1'b1;
                                frame_size  <= cand_fs;
                                hdr_q <= {cand[16:9], cand[7:4], cand[1:0]};
                            end else begin
                                state     <= HUNT;
                                locked    <= 1'b0;
                                sync_lost <= 1'b1;
                            end
                        end else if (fwd) begin
                            axiod <= axiid;
                            axiov <= 1'b1;
                        end
                    end
                    default: state <= HUNT;
                endcase
            end
        end
    end

    assign prot        = hdr_q[13];
    assign bitrate_idx = hdr_q[12:9];
    assign samp_rate   = hdr_q[8:7];
    assign padding     = hdr_q[6];
    assign mode        = hdr_q[5:4];
    assign mode_ext    = hdr_q[3:2];
    assign emphasis    = hdr_q[1:0];

endmodule
